// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus used by the fetch stage.
// The master issues word reads; the slave accepts them and returns one response per accepted request.
interface instr_fetch_unit_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: PC register, single-outstanding imem reads, and a small instruction/PC FIFO
// feeding decode, with decode stall and execute redirect/flush.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    instr_fetch_unit_if.master        imem,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    input  logic                      stall,
    output logic                      instr_valid,
    output logic [31:0]               instr,
    output logic [31:0]               instr_pc
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [31:0]        fetch_pc_reg, fetch_pc_next;
    logic [31:0]        data_mem [FIFO_DEPTH];
    logic [31:0]        pc_mem   [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0]   count_reg;

    logic               fifo_empty, fifo_full;
    logic               req_valid, req_fire, push, pop, head_valid;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
    assign head_valid = !fifo_empty && !rst;
    assign req_fire   = req_valid && imem.imem_req_ready;
    // A redirect flushes the buffer, so nothing may be consumed in that cycle.
    assign pop        = head_valid && !stall && !redirect_valid;

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        req_valid     = 1'b0;
        push          = 1'b0;
        case (state_reg)
            REQ: begin
                // Only request when the response is guaranteed a free slot.
                req_valid = !fifo_full && !redirect_valid && !rst;
                if (req_fire) begin
                    state_next    = WAIT;
                    fetch_pc_next = fetch_pc_reg + 32'd4;
                end
            end
            WAIT: begin
                if (imem.imem_resp_valid) begin
                    state_next = REQ;
                    push       = !redirect_valid;
                end else if (redirect_valid) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (imem.imem_resp_valid) begin
                    state_next = REQ;
                end
            end
            default: state_next = REQ;
        endcase
        if (redirect_valid) begin
            fetch_pc_next = redirect_pc & 32'hFFFF_FFFC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= REQ;
            fetch_pc_reg <= RESET_PC;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            if (redirect_valid) begin
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                end
                if (push && !pop) begin
                    count_reg <= count_reg + CNT_W'(1);
                end else if (!push && pop) begin
                    count_reg <= count_reg - CNT_W'(1);
                end
            end
        end
    end

    // fetch_pc has already advanced past the word being returned.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= imem.imem_resp_data;
            pc_mem[wr_ptr_reg]   <= fetch_pc_reg - 32'd4;
        end
    end

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = fetch_pc_reg;

    assign instr_valid = head_valid;
    assign instr       = head_valid ? data_mem[rd_ptr_reg] : 32'h0;
    assign instr_pc    = head_valid ? pc_mem[rd_ptr_reg]   : 32'h0;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a per-cycle vector table for directed corner cases, then randomized
// memory timing / stall / redirect traffic checked against a program-order scoreboard.
module tb_instr_fetch_unit;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          FIFO_DEPTH = 2;
    localparam int          N_VEC      = 33;
    localparam int          N_RAND     = 1500;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    instr_fetch_unit_if imem ();

    instr_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (imem.master),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    typedef struct {
        logic        rst;
        logic        ready;
        logic        resp_valid;
        logic [31:0] resp_addr;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        stall;
        logic        exp_req_valid;
        logic [31:0] exp_req_addr;
        logic        exp_instr_valid;
        logic [31:0] exp_instr_pc;
    } vec_t;

    vec_t vecs [N_VEC];

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic vec_t mk(input logic r, input logic rdy, input logic rv, input logic [31:0] ra,
                                input logic rd, input logic [31:0] rpc, input logic st,
                                input logic erv, input logic [31:0] ea, input logic eiv,
                                input logic [31:0] epc);
        vec_t v;
        v.rst = r; v.ready = rdy; v.resp_valid = rv; v.resp_addr = ra;
        v.redirect = rd; v.redirect_pc = rpc; v.stall = st;
        v.exp_req_valid = erv; v.exp_req_addr = ea; v.exp_instr_valid = eiv; v.exp_instr_pc = epc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // scoreboard / memory-model state
    logic        owed, resp_now, prev_redirect, prev_hold;
    int          cd, pops;
    logic [31:0] owed_addr, req_pc, exp_pc, prev_pc, prev_instr, e_pc, e_instr;

    initial begin
        //            rst rdy rv  raddr         rd  rpc           st   erv eaddr         eiv epc
        vecs[0]  = mk(1, 1, 0, 32'h0,          0, 32'h0,         0,   0, 32'h0,         0, 32'h0);
        vecs[1]  = mk(1, 1, 0, 32'h0,          0, 32'h0,         0,   0, 32'h0,         0, 32'h0);
        vecs[2]  = mk(0, 1, 0, 32'h0,          0, 32'h0,         0,   1, 32'h0,         0, 32'h0);
        vecs[3]  = mk(0, 1, 1, 32'h0,          0, 32'h0,         0,   0, 32'h0,         0, 32'h0);
        vecs[4]  = mk(0, 1, 0, 32'h0,          0, 32'h0,         0,   1, 32'h4,         1, 32'h0);
        vecs[5]  = mk(0, 1, 1, 32'h4,          0, 32'h0,         0,   0, 32'h0,         0, 32'h0);
        vecs[6]  = mk(0, 1, 0, 32'h0,          0, 32'h0,         0,   1, 32'h8,         1, 32'h4);
        vecs[7]  = mk(0, 1, 1, 32'h8,          0, 32'h0,         0,   0, 32'h0,         0, 32'h0);
        // stall: buffer fills to two entries, then fetch stops
        vecs[8]  = mk(0, 1, 0, 32'h0,          0, 32'h0,         1,   1, 32'hC,         1, 32'h8);
        vecs[9]  = mk(0, 1, 1, 32'hC,          0, 32'h0,         1,   0, 32'h0,         1, 32'h8);
        vecs[10] = mk(0, 1, 0, 32'h0,          0, 32'h0,         1,   0, 32'h0,         1, 32'h8);
        vecs[11] = mk(0, 1, 0, 32'h0,          0, 32'h0,         1,   0, 32'h0,         1, 32'h8);
        vecs[12] = mk(0, 1, 0, 32'h0,          0, 32'h0,         1,   0, 32'h0,         1, 32'h8);
        vecs[13] = mk(0, 1, 0, 32'h0,          0, 32'h0,         0,   0, 32'h0,         1, 32'h8);
        vecs[14] = mk(0, 1, 0, 32'h0,          0, 32'h0,         0,   1, 32'h10,        1, 32'hC);
        // redirect while waiting; stale response three cycles later is dropped
        vecs[15] = mk(0, 1, 0, 32'h0,          1, 32'h100,       0,   0, 32'h0,         0, 32'h0);
        vecs[16] = mk(0, 1, 0, 32'h0,          0, 32'h0,         0,   0, 32'h0,         0, 32'h0);
        vecs[17] = mk(0, 1, 0, 32'h0,          0, 32'h0,         0,   0, 32'h0,         0, 32'h0);
        vecs[18] = mk(0, 1, 1, 32'h10,         0, 32'h0,         0,   0, 32'h0,         0, 32'h0);
        vecs[19] = mk(0, 1, 0, 32'h0,          0, 32'h0,         0,   1, 32'h100,       0, 32'h0);
        vecs[20] = mk(0, 1, 1, 32'h100,        0, 32'h0,         0,   0, 32'h0,         0, 32'h0);
        vecs[21] = mk(0, 1, 0, 32'h0,          0, 32'h0,         1,   1, 32'h104,       1, 32'h100);
        // redirect coincident with response: response discarded, buffer flushed
        vecs[22] = mk(0, 1, 1, 32'h104,        1, 32'h203,       1,   0, 32'h0,         1, 32'h100);
        vecs[23] = mk(0, 0, 0, 32'h0,          0, 32'h0,         0,   1, 32'h200,       0, 32'h0);
        // PC wrap at the top of the address space
        vecs[24] = mk(0, 1, 0, 32'h0,          1, 32'hFFFF_FFFF, 0,   0, 32'h0,         0, 32'h0);
        vecs[25] = mk(0, 1, 0, 32'h0,          0, 32'h0,         0,   1, 32'hFFFF_FFFC, 0, 32'h0);
        vecs[26] = mk(0, 1, 1, 32'hFFFF_FFFC,  0, 32'h0,         0,   0, 32'h0,         0, 32'h0);
        vecs[27] = mk(0, 1, 0, 32'h0,          0, 32'h0,         1,   1, 32'h0,         1, 32'hFFFF_FFFC);
        // reset while waiting with a buffered entry, then a stray response
        vecs[28] = mk(1, 1, 0, 32'h0,          0, 32'h0,         0,   0, 32'h0,         0, 32'h0);
        vecs[29] = mk(0, 0, 1, 32'h4,          0, 32'h0,         0,   1, 32'h0,         0, 32'h0);
        vecs[30] = mk(0, 1, 0, 32'h0,          0, 32'h0,         0,   1, 32'h0,         0, 32'h0);
        vecs[31] = mk(0, 1, 1, 32'h0,          0, 32'h0,         0,   0, 32'h0,         0, 32'h0);
        vecs[32] = mk(0, 0, 0, 32'h0,          0, 32'h0,         0,   1, 32'h4,         1, 32'h0);

        rst                  = 1'b1;
        imem.imem_req_ready  = 1'b0;
        imem.imem_resp_valid = 1'b0;
        imem.imem_resp_data  = 32'h0;
        redirect_valid       = 1'b0;
        redirect_pc          = 32'h0;
        stall                = 1'b0;

        for (int i = 0; i < N_VEC; i++) begin
            @(negedge clk);
            rst                  = vecs[i].rst;
            imem.imem_req_ready  = vecs[i].ready;
            imem.imem_resp_valid = vecs[i].resp_valid;
            imem.imem_resp_data  = mem_word(vecs[i].resp_addr);
            redirect_valid       = vecs[i].redirect;
            redirect_pc          = vecs[i].redirect_pc;
            stall                = vecs[i].stall;
            #1;
            e_pc    = vecs[i].exp_instr_valid ? vecs[i].exp_instr_pc : 32'h0;
            e_instr = vecs[i].exp_instr_valid ? mem_word(vecs[i].exp_instr_pc) : 32'h0;
            check($sformatf("v%0d_req_valid", i), 32'(imem.imem_req_valid), 32'(vecs[i].exp_req_valid));
            if (vecs[i].exp_req_valid) begin
                check($sformatf("v%0d_req_addr", i), imem.imem_req_addr, vecs[i].exp_req_addr);
            end
            check($sformatf("v%0d_instr_valid", i), 32'(instr_valid), 32'(vecs[i].exp_instr_valid));
            check($sformatf("v%0d_instr_pc", i), instr_pc, e_pc);
            check($sformatf("v%0d_instr", i), instr, e_instr);
            $display("[TB] vec %0d: req_valid=%0b addr=%h instr_valid=%0b instr_pc=%h instr=%h",
                     i, imem.imem_req_valid, imem.imem_req_addr, instr_valid, instr_pc, instr);
        end

        // randomized phase: fresh reset, then scoreboard-checked traffic
        @(negedge clk);
        rst = 1'b1; imem.imem_resp_valid = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        owed = 1'b0; cd = 0; pops = 0; owed_addr = 32'h0;
        req_pc = RESET_PC; exp_pc = RESET_PC;
        prev_redirect = 1'b0; prev_hold = 1'b0; prev_pc = 32'h0; prev_instr = 32'h0;
        imem.imem_req_ready = 1'b0;
        #1;

        for (int c = 0; c < N_RAND; c++) begin
            @(negedge clk);
            resp_now = 1'b0;
            if (owed) begin
                if (cd == 0) begin
                    resp_now = 1'b1;
                    owed     = 1'b0;
                end else begin
                    cd--;
                end
            end
            imem.imem_resp_valid = resp_now;
            imem.imem_resp_data  = resp_now ? mem_word(owed_addr) : $urandom();
            imem.imem_req_ready  = ($urandom_range(0, 9) < 7);
            stall                = ($urandom_range(0, 3) == 0);
            redirect_valid       = ($urandom_range(0, 19) == 0);
            redirect_pc          = $urandom();
            #1;

            if (prev_redirect) begin
                check("flush", 32'(instr_valid), 32'h0);
            end else if (prev_hold) begin
                check("hold_valid", 32'(instr_valid), 32'h1);
                check("hold_pc", instr_pc, prev_pc);
                check("hold_instr", instr, prev_instr);
            end
            if (instr_valid) begin
                check("instr_data", instr, mem_word(instr_pc));
                if (!stall && !redirect_valid) begin
                    check("instr_pc_order", instr_pc, exp_pc);
                    $display("[TB] pop %0d: pc=%h instr=%h", pops, instr_pc, instr);
                    exp_pc = exp_pc + 32'd4;
                    pops++;
                end
            end else begin
                check("empty_zero", instr | instr_pc, 32'h0);
            end
            if (redirect_valid) begin
                check("req_gated", 32'(imem.imem_req_valid), 32'h0);
            end
            if (imem.imem_req_valid && imem.imem_req_ready) begin
                check("one_outstanding", 32'(owed || resp_now), 32'h0);
                check("req_addr", imem.imem_req_addr, req_pc);
                req_pc    = req_pc + 32'd4;
                owed      = 1'b1;
                owed_addr = imem.imem_req_addr;
                cd        = $urandom_range(0, 2);
            end
            if (redirect_valid) begin
                req_pc = redirect_pc & 32'hFFFF_FFFC;
                exp_pc = req_pc;
            end
            prev_redirect = redirect_valid;
            prev_hold     = instr_valid && stall && !redirect_valid;
            prev_pc       = instr_pc;
            prev_instr    = instr;
        end

        check("progress", 32'(pops >= 50), 32'h1);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch stage of the RV32I core, directly upstream of decode and the immediate sign-extension logic.
- Keeps the PC, issues word reads to instruction memory over a valid/ready request plus response-valid interface, and queues returned instructions with their PCs in a small FIFO.
- Presents the FIFO head to decode. Supports decode back-pressure (stall) and branch/jump redirect with flush.

Parameters:
RESET_PC, 32'h00000000, PC fetched first after reset
FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
clk  in  1  core clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  32  fetch byte address, word aligned
imem_req_ready  in  1  memory accepts request this cycle
imem_resp_valid  in  1  read data valid (one per accepted request, >=1 cycle after accept)
imem_resp_data  in  32  fetched instruction word
redirect_valid  in  1  taken branch/jump from execute
redirect_pc  in  32  redirect target
stall  in  1  decode cannot accept instruction this cycle
instr_valid  out  1  instr/instr_pc valid
instr  out  32  instruction word to decode/sign-extend
instr_pc  out  32  PC of instr

Behaviour:
- Reset (rst=1 at edge):
  - state=REQ, fetch_pc=RESET_PC, FIFO empty.
  - While rst is high: imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0.
- Outputs:
  - instr_valid = FIFO non-empty; instr/instr_pc = head entry.
  - instr and instr_pc are 0 when the FIFO is empty.
  - All outputs come from registers or state decode, with no combinational path from imem_resp_* to instr*.
- At most one outstanding memory request.
- States:
  - REQ:
    - imem_req_valid=1 iff FIFO count < FIFO_DEPTH and redirect_valid=0; imem_req_addr=fetch_pc.
    - On imem_req_valid && imem_req_ready: fetch_pc<=fetch_pc+4 (mod 2^32, wraps FFFFFFFC->0), go to WAIT.
    - imem_resp_valid in REQ is ignored (stray/pre-reset response).
  - WAIT:
    - imem_req_valid=0.
    - On imem_resp_valid: push {imem_resp_data, fetch_pc-4}, go to REQ.
  - DROP:
    - imem_req_valid=0.
    - On imem_resp_valid: discard the data, go to REQ.
- Pop: when instr_valid && !stall && !redirect_valid, the head is consumed at the edge.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - A push never overflows, because a request is only issued when count < FIFO_DEPTH and count cannot increase while waiting.
- Redirect (redirect_valid=1 at edge) has highest priority after rst:
  - FIFO cleared: instr_valid=0 next cycle, and no pop occurs that cycle.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - State transitions:
    - REQ -> REQ.
    - WAIT without resp -> DROP.
    - WAIT with resp in the same cycle -> REQ, response discarded.
    - DROP -> DROP (still owes one response); if resp arrives the same cycle -> REQ.
- Stall holds instr, instr_pc and instr_valid stable. Fetching continues until the FIFO is full.
- Latency:
  - First request is issued the first cycle after rst deasserts.
  - An instruction appears on instr the cycle after its imem_resp_valid.
  - With a zero-wait memory (ready=1, resp 1 cycle after accept), steady-state throughput is 1 instruction / 2 cycles.

Test Plan:
- Reset, RESET_PC=0, ready=1, resp 1 cycle after accept, stall=0 -> requests at 0x0,0x4,0x8; decode sees PCs 0x0,0x4,0x8 in order, each instr matching the memory model, 2 cycles apart.
- stall=1 held 10 cycles -> exactly 2 entries buffered, imem_req_valid=0 thereafter, instr/instr_pc unchanged; release stall -> 0x?0,0x?4 drained back-to-back.
- Redirect to 0x100 while in WAIT, response arrives 3 cycles later -> that response is dropped, next request addr=0x100, and the first instr_pc after redirect is 0x100.
- Redirect to 0x203 in the same cycle as imem_resp_valid -> response discarded, FIFO flushed, next request addr=0x200.
- fetch_pc=0xFFFFFFFC fetched -> next request addr=0x00000000.
- rst asserted in WAIT, then stray imem_resp_valid one cycle after rst deasserts -> ignored; first instr_pc out is RESET_PC.
